atm_session_ctrl: RTL and testbench

- Per-session transaction controller directly downstream of the card/database stage.
- Consumes the registered `balance` and `wrong_psw` from that stage.
- Sequences password attempts, lockout, user operations and timeouts.
- Returns `op_done` and `updated_balance` to that stage to commit results.

---
 rtl/atm_session_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_session_ctrl.sv
// -----------------------------------------------------------------------------
// atm_session_ctrl
//
// Per-session transaction controller that sits directly downstream of the
// card/database stage. It walks a card holder through password entry (with a
// lockout after max_tries consecutive failures), accepts inquiry / withdraw /
// deposit / end-session requests, and hands the committed balance back to the
// database stage with a one-cycle op_done strobe. Idle sessions time out and
// eject the card. Pulling the card aborts whatever is in flight.
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   card_in         card present (level)
//   psw_valid       one-cycle strobe: password submitted
//   wrong_psw       upstream registered password-mismatch flag (valid in AUTH)
//   balance         upstream registered balance of the current card
//   op_valid        one-cycle strobe: operation request (honoured in MENU only)
//   op_sel          00 inquiry, 01 withdraw, 10 deposit, 11 end session
//   amount          operation amount, sampled with op_valid
//   op_done         one-cycle commit strobe to upstream
//   updated_balance balance value upstream writes back
//   status          00 ok, 01 insufficient funds, 10 overflow, 11 locked
//   card_eject      request card ejection
//   card_locked     card retained after max_tries failures
//   session_active  high in MENU / EXEC / OPDONE / SETTLE
//
// Every output is a flop. Outputs are loaded from the next-state decision, so
// an output "belonging" to a state is visible for exactly the cycles the FSM
// spends in that state.
// -----------------------------------------------------------------------------
module atm_session_ctrl #(
  parameter int balance_width  = 20,
  parameter int max_tries      = 3,
  parameter int timeout_cycles = 1000,
  parameter int timer_width    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     card_in,
  input  logic                     psw_valid,
  input  logic                     wrong_psw,
  input  logic [balance_width-1:0] balance,
  input  logic                     op_valid,
  input  logic [1:0]               op_sel,
  input  logic [balance_width-1:0] amount,
  output logic                     op_done,
  output logic [balance_width-1:0] updated_balance,
  output logic [1:0]               status,
  output logic                     card_eject,
  output logic                     card_locked,
  output logic                     session_active
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_PSW,
    S_AUTH,
    S_MENU,
    S_EXEC,
    S_OPDONE,
    S_SETTLE,
    S_EJECT,
    S_LOCKED
  } state_e;

  typedef enum logic [1:0] {
    OP_INQUIRY  = 2'b00,
    OP_WITHDRAW = 2'b01,
    OP_DEPOSIT  = 2'b10,
    OP_END      = 2'b11
  } op_e;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_NO_FUNDS = 2'b01;
  localparam logic [1:0] ST_OVERFLOW = 2'b10;
  localparam logic [1:0] ST_LOCKED   = 2'b11;

  // tries only ever holds 0 .. max_tries-1; the lockout decision happens on
  // the attempt that would reach max_tries.
  localparam int tries_width = (max_tries > 1) ? $clog2(max_tries) : 1;

  localparam logic [timer_width-1:0] timer_last = timer_width'(timeout_cycles - 1);
  localparam logic [timer_width-1:0] timer_one  = timer_width'(1);
  localparam logic [tries_width-1:0] tries_one  = tries_width'(1);

  state_e                   state_q, state_d;
  logic [timer_width-1:0]   timer_q, timer_d;
  logic [tries_width-1:0]   tries_q, tries_d;
  op_e                      op_q;
  logic [balance_width-1:0] amount_q;
  logic                     latch_op;

  logic [balance_width:0]   dep_sum;
  logic [balance_width-1:0] res_balance;
  logic [1:0]               res_status;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default at the top of the block, so
  // no path through the case statement can leave one unassigned and infer a
  // latch.
  always_comb begin
    state_d  = state_q;
    timer_d  = '0;
    tries_d  = tries_q;
    latch_op = 1'b0;

    // Card removal overrides everything outside IDLE.
    if (state_q != S_IDLE && !card_in) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (card_in) begin
            state_d = S_WAIT_PSW;
            tries_d = '0;
          end
        end

        S_WAIT_PSW: begin
          if (psw_valid) begin
            state_d = S_AUTH;
          end else if (timer_q == timer_last) begin
            state_d = S_EJECT;
          end else begin
            timer_d = timer_q + timer_one;
          end
        end

        S_AUTH: begin
          if (!wrong_psw) begin
            state_d = S_MENU;
            tries_d = '0;
          end else if (int'(tries_q) + 1 == max_tries) begin
            state_d = S_LOCKED;
          end else begin
            state_d = S_WAIT_PSW;
            tries_d = tries_q + tries_one;
          end
        end

        S_MENU: begin
          if (op_valid) begin
            latch_op = 1'b1;
            state_d  = (op_e'(op_sel) == OP_END) ? S_EJECT : S_EXEC;
          end else if (timer_q == timer_last) begin
            state_d = S_EJECT;
          end else begin
            timer_d = timer_q + timer_one;
          end
        end

        S_EXEC:   state_d = S_OPDONE;
        S_OPDONE: state_d = S_SETTLE;
        S_SETTLE: state_d = S_MENU;   // upstream reloads balance here

        // Only card removal (handled above) leaves these states.
        S_EJECT,
        S_LOCKED: state_d = state_q;

        default:  state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Operation datapath, evaluated against the live balance during EXEC
  // ---------------------------------------------------------------------------
  always_comb begin
    dep_sum     = {1'b0, balance} + {1'b0, amount_q};
    res_balance = balance;
    res_status  = ST_OK;
    case (op_q)
      OP_WITHDRAW: begin
        if (amount_q > balance) begin
          res_status = ST_NO_FUNDS;
        end else begin
          res_balance = balance - amount_q;   // withdrawing the full balance is legal
        end
      end
      OP_DEPOSIT: begin
        if (dep_sum[balance_width]) begin
          res_status = ST_OVERFLOW;
        end else begin
          res_balance = dep_sum[balance_width-1:0];
        end
      end
      default: begin
        res_balance = balance;
        res_status  = ST_OK;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      timer_q         <= '0;
      tries_q         <= '0;
      op_q            <= OP_INQUIRY;
      amount_q        <= '0;
      op_done         <= 1'b0;
      updated_balance <= '0;
      status          <= ST_OK;
      card_eject      <= 1'b0;
      card_locked     <= 1'b0;
      session_active  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tries_q <= tries_d;

      if (latch_op) begin
        op_q     <= op_e'(op_sel);
        amount_q <= amount;
      end

      op_done        <= (state_d == S_OPDONE);
      card_eject     <= (state_d == S_EJECT);
      card_locked    <= (state_d == S_LOCKED);
      session_active <= (state_d inside {S_MENU, S_EXEC, S_OPDONE, S_SETTLE});

      // Outside an operation the write-back value mirrors the stored balance,
      // so a write-back triggered by card removal never corrupts the account.
      // An operation aborted in EXEC therefore also reloads the stored value.
      if (state_q == S_EXEC) begin
        updated_balance <= (state_d == S_OPDONE) ? res_balance : balance;
      end else if (state_q != S_OPDONE && state_q != S_SETTLE) begin
        updated_balance <= balance;
      end

      if (state_d == S_IDLE) begin
        status <= ST_OK;
      end else if (state_d == S_LOCKED) begin
        status <= ST_LOCKED;
      end else if (state_q == S_EXEC) begin
        status <= res_status;
      end
    end
  end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// -----------------------------------------------------------------------------
// tb_atm_session_ctrl
//
// Self-checking bench for atm_session_ctrl. A table of directed operations with
// hand-computed results, hand-written sequences for lockout, timeouts, card
// removal and reset, then a randomized run checked against an arithmetic
// account model. The bench plays the database stage: it supplies balance and
// reloads it with the expected committed value after every operation.
// -----------------------------------------------------------------------------
module tb_atm_session_ctrl;

  localparam int BW = 20;
  localparam int MT = 3;
  localparam int TO = 1000;
  localparam int TW = 10;
  localparam longint BAL_MAX = (longint'(1) << BW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          card_in = 1'b0;
  logic          psw_valid = 1'b0;
  logic          wrong_psw = 1'b0;
  logic [BW-1:0] balance = '0;
  logic          op_valid = 1'b0;
  logic [1:0]    op_sel = 2'b00;
  logic [BW-1:0] amount = '0;
  logic          op_done;
  logic [BW-1:0] updated_balance;
  logic [1:0]    status;
  logic          card_eject;
  logic          card_locked;
  logic          session_active;

  int n_cmp  = 0;
  int n_fail = 0;

  atm_session_ctrl #(
    .balance_width (BW),
    .max_tries     (MT),
    .timeout_cycles(TO),
    .timer_width   (TW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .card_in        (card_in),
    .psw_valid      (psw_valid),
    .wrong_psw      (wrong_psw),
    .balance        (balance),
    .op_valid       (op_valid),
    .op_sel         (op_sel),
    .amount         (amount),
    .op_done        (op_done),
    .updated_balance(updated_balance),
    .status         (status),
    .card_eject     (card_eject),
    .card_locked    (card_locked),
    .session_active (session_active)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [1:0]    sel;
    logic [BW-1:0] bal;
    logic [BW-1:0] amt;
    logic [BW-1:0] exp_bal;
    logic [1:0]    exp_st;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    card_in = 0; psw_valid = 0; wrong_psw = 0; op_valid = 0; op_sel = 0; amount = 0;
    rst = 0;
    repeat (2) step();
    @(negedge clk);
    rst = 1;
    step();
  endtask

  // Card in, one correct password; returns one unit after MENU entry.
  task automatic login(input logic [BW-1:0] bal);
    balance = bal;
    card_in = 1;
    step();                                  // WAIT_PSW
    psw_valid = 1; wrong_psw = 0;
    step();                                  // AUTH
    psw_valid = 0;
    step();                                  // MENU
  endtask

  task automatic wrong_attempt();
    psw_valid = 1; wrong_psw = 1;
    step();                                  // AUTH
    psw_valid = 0;
    step();                                  // WAIT_PSW or LOCKED
    wrong_psw = 0;
  endtask

  // Issue one operation from MENU and check the commit; returns in MENU.
  task automatic run_op(input string name, input logic [1:0] sel, input logic [BW-1:0] bal,
                        input logic [BW-1:0] amt, input logic [BW-1:0] exp_bal,
                        input logic [1:0] exp_st);
    balance = bal;
    op_valid = 1; op_sel = sel; amount = amt;
    step();                                  // EXEC
    op_valid = 0;
    amount = BW'($urandom);                  // amount must have been latched
    op_sel = 2'($urandom);
    check({name, " early_done"}, op_done, 0);
    step();                                  // OPDONE
    check({name, " done"}, op_done, 1);
    check({name, " balance"}, updated_balance, exp_bal);
    check({name, " status"}, status, exp_st);
    balance = exp_bal;                       // upstream commits
    step();                                  // SETTLE
    check({name, " done_pulse"}, op_done, 0);
    step();                                  // MENU
  endtask

  // Account rules in plain arithmetic.
  function automatic void ref_op(input int sel, input longint bal, input longint amt,
                                 output longint nb, output int st);
    nb = bal;
    st = 0;
    if (sel == 1) begin
      if (amt > bal) st = 1;
      else nb = bal - amt;
    end else if (sel == 2) begin
      if (bal + amt > BAL_MAX) st = 2;
      else nb = bal + amt;
    end
  endfunction

  initial begin
    longint db_bal, nb, amt_l;
    int     st, sel;

    vecs[0] = '{2'b00, BW'(500),     BW'(0),        BW'(500),     2'b00};
    vecs[1] = '{2'b01, BW'(500),     BW'(200),      BW'(300),     2'b00};
    vecs[2] = '{2'b01, BW'(300),     BW'(300),      BW'(0),       2'b00};
    vecs[3] = '{2'b01, BW'(500),     BW'(600),      BW'(500),     2'b01};
    vecs[4] = '{2'b10, BW'(1048575), BW'(1),        BW'(1048575), 2'b10};
    vecs[5] = '{2'b10, BW'(1000),    BW'(100),      BW'(1100),    2'b00};
    vecs[6] = '{2'b01, BW'(500),     BW'(501),      BW'(500),     2'b01};
    vecs[7] = '{2'b10, BW'(0),       BW'(1048575),  BW'(1048575), 2'b00};
    vecs[8] = '{2'b10, BW'(1048575), BW'(0),        BW'(1048575), 2'b00};
    vecs[9] = '{2'b01, BW'(0),       BW'(0),        BW'(0),       2'b00};

    // ---- reset state -------------------------------------------------------
    balance = BW'(123);
    #2;
    check("rst op_done", op_done, 0);
    check("rst updated_balance", updated_balance, 0);
    check("rst status", status, 0);
    check("rst card_eject", card_eject, 0);
    check("rst card_locked", card_locked, 0);
    check("rst session_active", session_active, 0);
    do_reset();
    check("idle follows balance", updated_balance, 123);

    // ---- directed operation table -----------------------------------------
    login(BW'(500));
    check("login session_active", session_active, 1);
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].bal, vecs[i].amt,
             vecs[i].exp_bal, vecs[i].exp_st);
    end
    balance = BW'(777);
    step();
    check("menu follows balance", updated_balance, 777);
    check("menu status held", status, 0);

    // withdraw 200 then immediate withdraw 300 after SETTLE
    run_op("wd200", 2'b01, BW'(500), BW'(200), BW'(300), 2'b00);
    run_op("wd300", 2'b01, BW'(300), BW'(300), BW'(0), 2'b00);

    // psw_valid in MENU is ignored
    psw_valid = 1; wrong_psw = 1;
    step();
    psw_valid = 0; wrong_psw = 0;
    step();
    check("psw in menu ignored", session_active, 1);

    // end session -> eject next cycle
    op_valid = 1; op_sel = 2'b11;
    step();
    op_valid = 0;
    check("end eject", card_eject, 1);
    check("end no done", op_done, 0);
    check("end inactive", session_active, 0);
    card_in = 0;
    step();
    check("eject cleared", card_eject, 0);

    // ---- lockout -----------------------------------------------------------
    card_in = 1;
    step();
    wrong_attempt();
    check("wrong1 not locked", card_locked, 0);
    wrong_attempt();
    check("wrong2 not locked", card_locked, 0);
    wrong_attempt();
    check("lock card_locked", card_locked, 1);
    check("lock status", status, 3);
    check("lock no eject", card_eject, 0);
    check("lock no done", op_done, 0);
    repeat (3) step();
    check("lock holds", card_locked, 1);
    card_in = 0;
    step();
    check("unlock card_locked", card_locked, 0);
    check("unlock status", status, 0);

    // two wrong then correct, in two sessions: tries must start from zero
    for (int s = 0; s < 2; s++) begin
      card_in = 1;
      step();
      wrong_attempt();
      wrong_attempt();
      check($sformatf("s%0d two wrong no lock", s), card_locked, 0);
      psw_valid = 1;
      step();
      psw_valid = 0;
      step();
      check($sformatf("s%0d third ok active", s), session_active, 1);
      card_in = 0;
      step();
      check($sformatf("s%0d removal idle", s), session_active, 0);
    end

    // ---- timeouts ----------------------------------------------------------
    login(BW'(42));
    repeat (TO - 1) step();
    check("menu timeout early", card_eject, 0);
    step();
    check("menu timeout eject", card_eject, 1);
    card_in = 0;
    step();

    card_in = 1;
    step();                                  // WAIT_PSW entry
    repeat (TO - 1) step();
    check("psw timeout early", card_eject, 0);
    step();
    check("psw timeout eject", card_eject, 1);
    card_in = 0;
    step();

    // ---- card removal during EXEC: no op_done, status cleared --------------
    login(BW'(500));
    run_op("pre_abort", 2'b01, BW'(500), BW'(600), BW'(500), 2'b01);
    op_valid = 1; op_sel = 2'b01; amount = BW'(100);
    step();                                  // EXEC
    op_valid = 0; card_in = 0;
    step();
    check("abort no done", op_done, 0);
    check("abort status", status, 0);
    check("abort keeps balance", updated_balance, 500);
    step();
    check("abort no late done", op_done, 0);

    // ---- removal coinciding with OPDONE still completes -------------------
    login(BW'(500));
    op_valid = 1; op_sel = 2'b10; amount = BW'(5);
    step();
    op_valid = 0;
    step();                                  // OPDONE
    check("opdone removal done", op_done, 1);
    check("opdone removal bal", updated_balance, 505);
    card_in = 0;
    step();
    check("opdone removal idle", op_done, 0);

    // ---- reset asserted in OPDONE -----------------------------------------
    login(BW'(500));
    op_valid = 1; op_sel = 2'b01; amount = BW'(900);
    step();
    op_valid = 0;
    step();                                  // OPDONE
    check("pre-rst done", op_done, 1);
    check("pre-rst status", status, 1);
    #2;
    rst = 0;
    #1;
    check("mid rst op_done", op_done, 0);
    check("mid rst balance", updated_balance, 0);
    check("mid rst status", status, 0);
    check("mid rst active", session_active, 0);
    card_in = 0;
    @(negedge clk);
    rst = 1;
    step();

    // ---- randomized operations against the account model ------------------
    db_bal = longint'($urandom_range(0, 1000000));
    login(BW'(db_bal));
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        op_valid = 1; op_sel = 2'b11;
        step();
        op_valid = 0;
        check($sformatf("rnd%0d end eject", i), card_eject, 1);
        card_in = 0;
        step();
        db_bal = longint'($urandom_range(0, 1048575));
        login(BW'(db_bal));
      end else begin
        sel = int'($urandom_range(0, 2));
        case ($urandom_range(0, 3))
          0:       amt_l = longint'($urandom_range(0, 1048575));
          1:       amt_l = db_bal;
          2:       amt_l = (db_bal + 1) & BAL_MAX;
          default: amt_l = longint'($urandom_range(0, 300));
        endcase
        if (sel == 2 && $urandom_range(0, 3) == 0) amt_l = BAL_MAX - db_bal + longint'($urandom_range(0, 1));
        amt_l = amt_l & BAL_MAX;
        ref_op(sel, db_bal, amt_l, nb, st);
        run_op($sformatf("rnd%0d", i), 2'(sel), BW'(db_bal), BW'(amt_l), BW'(nb), 2'(st));
        db_bal = nb;
      end
    end
    card_in = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
